phase_fire_ctl: RTL and testbench

Phase-angle firing controller for one mains phase. It consumes the debounced zero-cross pulse and missing-phase flag from the phase debouncer, and measures the half-cycle period in enable ticks. From a requested dimmer level it computes a firing delay and emits one gate pulse per half-cycle to the triac driver. It runs in the same clock domain and on the same enable tick as the debouncer (10 µs tick).

---
 rtl/phase_fire_ctl.sv | 212 +++++++++++++++++++++
 tb/tb_phase_fire_ctl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/phase_fire_ctl.sv
// Phase-angle firing controller: measures the mains half-cycle, derives a firing delay
// from the dimmer level and emits one gate pulse per half-cycle. Optional macro: PHASE_FIRE_SOFTSTART_EN.
module phase_fire_ctl #(
  parameter int              PERW   = 12,
  parameter logic [PERW-1:0] MINPER = 12'd700,
  parameter logic [PERW-1:0] MAXPER = 12'd1200,
  parameter logic [7:0]      GATEW  = 8'd20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            dbphase,
  input  logic            missing,
  input  logic [7:0]      level,
  output logic            gate,
  output logic [PERW-1:0] period,
  output logic            locked
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FIRE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int              PRODW    = PERW + 8;
  localparam logic [PERW-1:0] PCNT_MAX = {PERW{1'b1}};
  localparam logic [PERW-1:0] PONE     = {{(PERW-1){1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [PERW-1:0] pcnt_q, pcnt_d;
  logic [PERW-1:0] period_q, period_d;
  logic [1:0]      valcnt_q, valcnt_d;
  logic            locked_q, locked_d;
  logic            gate_q, gate_d;
  logic [PERW-1:0] tcnt_q, tcnt_d;
  logic [PERW-1:0] delay_q, delay_d;
  logic [7:0]      gcnt_q, gcnt_d;

  logic            in_range;
  logic [7:0]      lvl;
  logic [7:0]      lvl_inv;
  logic [PRODW-1:0] prod;
  logic [PERW-1:0] delay_calc;

  assign in_range = (pcnt_q >= MINPER) && (pcnt_q <= MAXPER);

`ifdef PHASE_FIRE_SOFTSTART_EN
  logic [7:0] eff_q, eff_d;

  // Slew the effective level by one step per accepted zero cross.
  always_comb begin
    eff_d = eff_q;
    if (dbphase && !missing) begin
      if (eff_q < level) begin
        eff_d = eff_q + 8'd1;
      end else if (eff_q > level) begin
        eff_d = eff_q - 8'd1;
      end else begin
        eff_d = eff_q;
      end
    end else begin
      eff_d = eff_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      eff_q <= 8'd0;
    end else begin
      eff_q <= eff_d;
    end
  end

  assign lvl = eff_d;
`else
  assign lvl = level;
`endif

  // Delay uses the period held before this zero cross updates it.
  assign lvl_inv    = 8'd255 - lvl;
  assign prod       = PRODW'(period_q) * PRODW'(lvl_inv);
  assign delay_calc = prod[PRODW-1:8];

  always_comb begin
    pcnt_d   = pcnt_q;
    period_d = period_q;
    valcnt_d = valcnt_q;
    locked_d = locked_q;
    if (missing) begin
      valcnt_d = 2'd0;
      locked_d = 1'b0;
      if (enable && (pcnt_q != PCNT_MAX)) begin
        pcnt_d = pcnt_q + PONE;
      end else begin
        pcnt_d = pcnt_q;
      end
    end else if (dbphase) begin
      pcnt_d = {PERW{1'b0}};
      if (in_range) begin
        period_d = pcnt_q;
        valcnt_d = (valcnt_q >= 2'd2) ? 2'd2 : (valcnt_q + 2'd1);
        locked_d = (valcnt_q >= 2'd1);
      end else begin
        valcnt_d = 2'd0;
        locked_d = 1'b0;
      end
    end else begin
      if (enable && (pcnt_q != PCNT_MAX)) begin
        pcnt_d = pcnt_q + PONE;
      end else begin
        pcnt_d = pcnt_q;
      end
    end
  end

  // A zero cross always drops the gate first, so a pulse never spans two half-cycles.
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    tcnt_d  = tcnt_q;
    delay_d = delay_q;
    gcnt_d  = gcnt_q;
    if (missing) begin
      state_d = ST_IDLE;
      gate_d  = 1'b0;
    end else if (dbphase) begin
      gate_d = 1'b0;
      if (locked_d && (lvl != 8'd0)) begin
        state_d = ST_WAIT;
        tcnt_d  = {PERW{1'b0}};
        delay_d = delay_calc;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          gate_d = 1'b0;
        end
        ST_WAIT: begin
          if (enable) begin
            if (tcnt_q == delay_q) begin
              gate_d  = 1'b1;
              gcnt_d  = GATEW - 8'd1;
              state_d = ST_FIRE;
            end else begin
              tcnt_d = tcnt_q + PONE;
            end
          end else begin
            tcnt_d = tcnt_q;
          end
        end
        ST_FIRE: begin
          if (enable) begin
            if (gcnt_q == 8'd0) begin
              gate_d  = 1'b0;
              state_d = ST_DONE;
            end else begin
              gcnt_d = gcnt_q - 8'd1;
            end
          end else begin
            gcnt_d = gcnt_q;
          end
        end
        ST_DONE: begin
          gate_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          gate_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= {PERW{1'b0}};
      period_q <= {PERW{1'b0}};
      valcnt_q <= 2'd0;
      locked_q <= 1'b0;
      gate_q   <= 1'b0;
      tcnt_q   <= {PERW{1'b0}};
      delay_q  <= {PERW{1'b0}};
      gcnt_q   <= 8'd0;
    end else begin
      pcnt_q   <= pcnt_d;
      period_q <= period_d;
      valcnt_q <= valcnt_d;
      locked_q <= locked_d;
      gate_q   <= gate_d;
      tcnt_q   <= tcnt_d;
      delay_q  <= delay_d;
      gcnt_q   <= gcnt_d;
    end
  end

  assign gate   = gate_q;
  assign period = period_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_phase_fire_ctl.sv
// Directed table-driven bench for phase_fire_ctl (default build, soft-start disabled).
module tb_phase_fire_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dbphase;
  logic        missing;
  logic [7:0]  level;
  logic        gate;
  logic [11:0] period;
  logic        locked;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  phase_fire_ctl dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .dbphase (dbphase),
    .missing (missing),
    .level   (level),
    .gate    (gate),
    .period  (period),
    .locked  (locked)
  );

  // One half-cycle: dbphase on the first clk, then n enabled clks.
  typedef struct {
    logic [7:0] lv;
    int         n;
    int         exp_locked;
    int         exp_period;
    int         exp_rise;
    int         exp_width;
  } vec_t;

  vec_t vecs[14];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_half(input logic [7:0] lv, input int n,
                         output int lk, output int per, output int g0,
                         output int rise, output int width);
    level   = lv;
    enable  = 1'b1;
    dbphase = 1'b1;
    tick();
    dbphase = 1'b0;
    lk    = int'(locked);
    per   = int'(period);
    g0    = int'(gate);
    rise  = 0;
    width = 0;
    for (int j = 1; j <= n; j++) begin
      tick();
      if (gate) begin
        if (rise == 0) rise = j;
        width++;
      end
    end
  endtask

  initial begin
    int lk, per, g0, rise, width;

    vecs[0]  = '{8'd128, 1000, 0, 0,    0,   0};
    vecs[1]  = '{8'd128, 1000, 0, 1000, 0,   0};
    vecs[2]  = '{8'd128, 1000, 1, 1000, 497, 20};
    vecs[3]  = '{8'd255, 1000, 1, 1000, 1,   20};
    vecs[4]  = '{8'd0,   1000, 1, 1000, 0,   0};
    vecs[5]  = '{8'd128, 600,  1, 1000, 497, 20};
    vecs[6]  = '{8'd128, 600,  0, 1000, 0,   0};
    vecs[7]  = '{8'd128, 833,  0, 1000, 0,   0};
    vecs[8]  = '{8'd128, 833,  0, 833,  0,   0};
    vecs[9]  = '{8'd128, 833,  1, 833,  414, 20};
    vecs[10] = '{8'd200, 1000, 1, 833,  179, 20};
    vecs[11] = '{8'd8,   1000, 1, 1000, 804, 20};
    vecs[12] = '{8'd8,   970,  1, 1000, 965, 6};
    vecs[13] = '{8'd8,   1000, 1, 970,  965, 20};

    rst     = 1'b1;
    enable  = 1'b0;
    dbphase = 1'b0;
    missing = 1'b0;
    level   = 8'd0;
    repeat (3) tick();
    chk("reset.gate",   int'(gate),   0);
    chk("reset.locked", int'(locked), 0);
    chk("reset.period", int'(period), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      do_half(vecs[i].lv, vecs[i].n, lk, per, g0, rise, width);
      chk($sformatf("v%0d.locked", i), lk,    vecs[i].exp_locked);
      chk($sformatf("v%0d.period", i), per,   vecs[i].exp_period);
      chk($sformatf("v%0d.gate_at_zc", i), g0, 0);
      chk($sformatf("v%0d.rise", i),   rise,  vecs[i].exp_rise);
      chk($sformatf("v%0d.width", i),  width, vecs[i].exp_width);
    end

    // missing during FIRE, dbphase ignored while missing, then relock
    level   = 8'd255;
    dbphase = 1'b1;
    tick();
    dbphase = 1'b0;
    chk("ms.locked_before", int'(locked), 1);
    repeat (3) tick();
    chk("ms.gate_fire", int'(gate), 1);
    missing = 1'b1;
    tick();
    chk("ms.gate_off",   int'(gate),   0);
    chk("ms.locked_off", int'(locked), 0);
    tick();
    dbphase = 1'b1;
    tick();
    dbphase = 1'b0;
    chk("ms.gate_held_low", int'(gate), 0);
    tick();
    missing = 1'b0;
    repeat (993) tick();
    chk("ms.gate_idle", int'(gate), 0);

    do_half(8'd128, 1000, lk, per, g0, rise, width);
    chk("rl1.locked", lk,   0);
    chk("rl1.period", per,  1000);
    chk("rl1.rise",   rise, 0);
    do_half(8'd128, 1000, lk, per, g0, rise, width);
    chk("rl2.locked", lk,    1);
    chk("rl2.period", per,   1000);
    chk("rl2.rise",   rise,  497);
    chk("rl2.width",  width, 20);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
